// File: rtl/lzw_forward_code_gen.sv
// ----------------------------------------------------------------------------------------------
// lzw_forward_code_gen
//
// LZW compress-side code generator. Consumes a byte stream, walks a hashed dictionary RAM and
// emits 14-bit codes. This block is the write side of the dictionary that the decompress path
// later reads back. Each dictionary entry is {valid[22], prefix_code[21:8], byte[7:0]}, and the
// code of a newly learned string is the RAM address it was written to.
//
// Optional build macro:
//   LZW_STATE_CNT_EN  adds saturating statistics counters (codes, collisions, packets) and makes
//                     I_state_clr live. Without it those ports are absent and I_state_clr is unused.
//
// Parameters:
//   RD_LAT        dictionary RAM read latency in clocks (rden -> dout valid), 1..4
//   INIT_ON_LAST  1: rebuild the dictionary after every packet, 0: only after reset
//
// Ports:
//   I_sys_clk, I_sys_rst_n   clock, asynchronous active-low reset
//   I_state_clr              clear statistics counters (counter build only)
//   I_data/_en/_last         byte input; taken only while O_data_ready=1
//   O_data_ready             block can accept a byte this cycle
//   O_compress_data/_en      emitted code and its 1-cycle strobe
//   O_compress_last          final code of the packet, coincides with its strobe
//   O_dictionary_*           dictionary RAM port (shared read/write address)
//   O_code_cnt, O_collision_cnt, O_pkt_cnt   statistics (counter build only)
// ----------------------------------------------------------------------------------------------
module lzw_forward_code_gen #(
  parameter int unsigned RD_LAT       = 2,
  parameter int unsigned INIT_ON_LAST = 1
) (
  input  logic        I_sys_clk,
  input  logic        I_sys_rst_n,
  input  logic        I_state_clr,
  input  logic [7:0]  I_data,
  input  logic        I_data_en,
  input  logic        I_data_last,
  output logic        O_data_ready,
  output logic [13:0] O_compress_data,
  output logic        O_compress_data_en,
  output logic        O_compress_last,
  output logic [13:0] O_dictionary_addr,
  output logic        O_dictionary_rden,
  input  logic [22:0] I_dictionary_dout,
  output logic        O_dictionary_wren,
  output logic [22:0] O_dictionary_din
`ifdef LZW_STATE_CNT_EN
  ,
  output logic [31:0] O_code_cnt,
  output logic [31:0] O_collision_cnt,
  output logic [31:0] O_pkt_cnt
`endif
);

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StRead,
    StWait,
    StCmp,
    StFlush
  } state_e;

  // Last value of the wait counter before moving to the compare state.
  localparam logic [2:0] WaitLast = 3'(RD_LAT - 1);

  state_e      state_q, state_d;
  logic [13:0] init_cnt_q, init_cnt_d;
  logic [2:0]  wait_cnt_q, wait_cnt_d;
  logic [13:0] prefix_q, prefix_d;
  logic        have_prefix_q, have_prefix_d;
  logic [7:0]  byte_q, byte_d;
  logic        last_q, last_d;
  logic [13:0] hash_q, hash_d;

  logic [13:0] code_q, code_d;
  logic        code_en_q, code_en_d;
  logic        code_last_q, code_last_d;
  logic [13:0] addr_q, addr_d;
  logic        rden_q, rden_d;
  logic        wren_q, wren_d;
  logic [22:0] din_q, din_d;

  logic        collision;

  // ------------------------------------------------------------------------------------------
  // Hash of (current prefix, incoming byte). Results below 0x100 are pushed up so that root
  // codes are never overwritten by learned strings.
  // ------------------------------------------------------------------------------------------
  logic [13:0] hash_raw;
  logic [13:0] hash_tgt;

  always_comb begin
    hash_raw = prefix_q ^ {I_data, I_data[5:0]};
    hash_tgt = (hash_raw[13:8] == 6'h00) ? (hash_raw | 14'h0100) : hash_raw;
  end

  // Dictionary entry fields as returned by the RAM.
  logic        dict_valid;
  logic [13:0] dict_prefix;
  logic [7:0]  dict_byte;
  logic        dict_hit;

  always_comb begin
    dict_valid  = I_dictionary_dout[22];
    dict_prefix = I_dictionary_dout[21:8];
    dict_byte   = I_dictionary_dout[7:0];
    dict_hit    = dict_valid && (dict_prefix == prefix_q) && (dict_byte == byte_q);
  end

  // ------------------------------------------------------------------------------------------
  // Next-state and registered-output logic
  // ------------------------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    init_cnt_d    = init_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    prefix_d      = prefix_q;
    have_prefix_d = have_prefix_q;
    byte_d        = byte_q;
    last_d        = last_q;
    hash_d        = hash_q;
    code_d        = code_q;
    code_en_d     = 1'b0;
    code_last_d   = 1'b0;
    addr_d        = addr_q;
    rden_d        = 1'b0;
    wren_d        = 1'b0;
    din_d         = din_q;
    collision     = 1'b0;

    unique case (state_q)
      StInit: begin
        // Roots 0x00..0xFF are pre-loaded as valid single-byte strings; everything else cleared.
        wren_d     = 1'b1;
        addr_d     = init_cnt_q;
        din_d      = (init_cnt_q[13:8] == 6'h00) ? {1'b1, 14'h0000, init_cnt_q[7:0]} : 23'h0;
        init_cnt_d = init_cnt_q + 14'd1;
        if (init_cnt_q == 14'h3FFF) begin
          state_d = StIdle;
        end
      end

      StIdle: begin
        if (I_data_en) begin
          byte_d = I_data;
          last_d = I_data_last;
          if (!have_prefix_q) begin
            // First byte of a packet: it becomes the prefix without a lookup.
            prefix_d      = {6'h00, I_data};
            have_prefix_d = 1'b1;
            if (I_data_last) begin
              state_d = StFlush;
            end
          end else begin
            // Read strobe is registered, so it is visible during the READ state.
            hash_d  = hash_tgt;
            addr_d  = hash_tgt;
            rden_d  = 1'b1;
            state_d = StRead;
          end
        end
      end

      StRead: begin
        wait_cnt_d = 3'd0;
        state_d    = StWait;
      end

      StWait: begin
        wait_cnt_d = wait_cnt_q + 3'd1;
        if (wait_cnt_q == WaitLast) begin
          state_d = StCmp;
        end
      end

      StCmp: begin
        if (dict_hit) begin
          // String already known: extend it.
          prefix_d = hash_q;
        end else begin
          code_d    = prefix_q;
          code_en_d = 1'b1;
          prefix_d  = {6'h00, byte_q};
          if (!dict_valid) begin
            wren_d = 1'b1;
            addr_d = hash_q;
            din_d  = {1'b1, prefix_q, byte_q};
          end else begin
            // Slot owned by another string; the new string is simply not learned.
            collision = 1'b1;
          end
        end
        state_d = last_q ? StFlush : StIdle;
      end

      StFlush: begin
        code_d        = prefix_q;
        code_en_d     = 1'b1;
        code_last_d   = 1'b1;
        have_prefix_d = 1'b0;
        init_cnt_d    = 14'h0000;
        state_d       = (INIT_ON_LAST != 0) ? StInit : StIdle;
      end

      default: begin
        state_d = StInit;
      end
    endcase
  end

  always_ff @(posedge I_sys_clk or negedge I_sys_rst_n) begin
    if (!I_sys_rst_n) begin
      state_q       <= StInit;
      init_cnt_q    <= 14'h0000;
      wait_cnt_q    <= 3'd0;
      prefix_q      <= 14'h0000;
      have_prefix_q <= 1'b0;
      byte_q        <= 8'h00;
      last_q        <= 1'b0;
      hash_q        <= 14'h0000;
      code_q        <= 14'h0000;
      code_en_q     <= 1'b0;
      code_last_q   <= 1'b0;
      addr_q        <= 14'h0000;
      rden_q        <= 1'b0;
      wren_q        <= 1'b0;
      din_q         <= 23'h0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      prefix_q      <= prefix_d;
      have_prefix_q <= have_prefix_d;
      byte_q        <= byte_d;
      last_q        <= last_d;
      hash_q        <= hash_d;
      code_q        <= code_d;
      code_en_q     <= code_en_d;
      code_last_q   <= code_last_d;
      addr_q        <= addr_d;
      rden_q        <= rden_d;
      wren_q        <= wren_d;
      din_q         <= din_d;
    end
  end

  assign O_data_ready       = (state_q == StIdle);
  assign O_compress_data    = code_q;
  assign O_compress_data_en = code_en_q;
  assign O_compress_last    = code_last_q;
  assign O_dictionary_addr  = addr_q;
  assign O_dictionary_rden  = rden_q;
  assign O_dictionary_wren  = wren_q;
  assign O_dictionary_din   = din_q;

  // ------------------------------------------------------------------------------------------
  // Statistics counters
  // ------------------------------------------------------------------------------------------
`ifdef LZW_STATE_CNT_EN
  logic [31:0] code_cnt_q;
  logic [31:0] collision_cnt_q;
  logic [31:0] pkt_cnt_q;

  // Clear takes priority over any same-cycle increment; all counters saturate.
  always_ff @(posedge I_sys_clk or negedge I_sys_rst_n) begin
    if (!I_sys_rst_n) begin
      code_cnt_q      <= 32'h0;
      collision_cnt_q <= 32'h0;
      pkt_cnt_q       <= 32'h0;
    end else if (I_state_clr) begin
      code_cnt_q      <= 32'h0;
      collision_cnt_q <= 32'h0;
      pkt_cnt_q       <= 32'h0;
    end else begin
      if (code_en_q && (code_cnt_q != 32'hFFFF_FFFF)) begin
        code_cnt_q <= code_cnt_q + 32'd1;
      end
      if (collision && (collision_cnt_q != 32'hFFFF_FFFF)) begin
        collision_cnt_q <= collision_cnt_q + 32'd1;
      end
      if ((state_q == StFlush) && (pkt_cnt_q != 32'hFFFF_FFFF)) begin
        pkt_cnt_q <= pkt_cnt_q + 32'd1;
      end
    end
  end

  assign O_code_cnt      = code_cnt_q;
  assign O_collision_cnt = collision_cnt_q;
  assign O_pkt_cnt       = pkt_cnt_q;
`else
  logic unused_cnt_inputs;
  assign unused_cnt_inputs = I_state_clr ^ collision;
`endif

endmodule

// File: tb/tb_lzw_forward_code_gen.sv
`timescale 1ns/1ps
module tb_lzw_forward_code_gen;

  localparam int unsigned RD_LAT = 2;

  logic        clk;
  logic        rst_n;
  logic        state_clr;
  logic [7:0]  data;
  logic        data_en;
  logic        data_last;
  logic        data_ready;
  logic [13:0] cdata;
  logic        cdata_en;
  logic        clast;
  logic [13:0] dict_addr;
  logic        dict_rden;
  logic [22:0] dict_dout;
  logic        dict_wren;
  logic [22:0] dict_din;
`ifdef LZW_STATE_CNT_EN
  logic [31:0] code_cnt;
  logic [31:0] collision_cnt;
  logic [31:0] pkt_cnt;
`endif

  int errors = 0;
  int checks = 0;

  lzw_forward_code_gen #(
    .RD_LAT      (RD_LAT),
    .INIT_ON_LAST(1)
  ) dut (
    .I_sys_clk          (clk),
    .I_sys_rst_n        (rst_n),
    .I_state_clr        (state_clr),
    .I_data             (data),
    .I_data_en          (data_en),
    .I_data_last        (data_last),
    .O_data_ready       (data_ready),
    .O_compress_data    (cdata),
    .O_compress_data_en (cdata_en),
    .O_compress_last    (clast),
    .O_dictionary_addr  (dict_addr),
    .O_dictionary_rden  (dict_rden),
    .I_dictionary_dout  (dict_dout),
    .O_dictionary_wren  (dict_wren),
    .O_dictionary_din   (dict_din)
`ifdef LZW_STATE_CNT_EN
    ,
    .O_code_cnt         (code_cnt),
    .O_collision_cnt    (collision_cnt),
    .O_pkt_cnt          (pkt_cnt)
`endif
  );

  initial clk = 1'b0;
  always #2 clk = ~clk;

  // Dictionary RAM model: read data appears RD_LAT clocks after the sampled rden and holds.
  logic [22:0] mem [16384];
  logic [22:0] rd_stg [RD_LAT];

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 23'h7FFFFF;
  end

  always @(posedge clk) begin
    if (dict_rden) rd_stg[0] <= mem[dict_addr];
    for (int i = 1; i < RD_LAT; i++) rd_stg[i] <= rd_stg[i-1];
    if (dict_wren) mem[dict_addr] = dict_din;
  end
  assign dict_dout = rd_stg[RD_LAT-1];

  // Output monitor. Learned-string writes are those that are valid and above the root range.
  logic [13:0] codes    [$];
  logic        lasts    [$];
  logic [13:0] wr_addrs [$];
  logic [22:0] wr_dins  [$];
  int          rden_cnt = 0;

  always @(negedge clk) begin
    if (cdata_en) begin
      codes.push_back(cdata);
      lasts.push_back(clast);
    end
    if (dict_wren && dict_din[22] && (dict_addr >= 14'h0100)) begin
      wr_addrs.push_back(dict_addr);
      wr_dins.push_back(dict_din);
    end
    if (dict_rden) rden_cnt++;
  end

  // Caller is at posedge+1; returns one cycle after the byte was presented to an IDLE block.
  task automatic send_byte(input logic [7:0] b, input logic l);
    int n;
    n = 0;
    while (!data_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    data      = b;
    data_last = l;
    data_en   = 1'b1;
    @(posedge clk); #1;
    data_en   = 1'b0;
    data_last = 1'b0;
  endtask

  task automatic test_reset();
    logic [55:0] obs;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    obs = {data_ready, cdata_en, clast, cdata, dict_rden, dict_wren, dict_addr, dict_din};
    checks++;
    if (obs !== 56'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", obs);
    end
`ifdef LZW_STATE_CNT_EN
    checks++;
    if ({code_cnt, collision_cnt, pkt_cnt} !== 96'h0) begin
      errors++;
      $display("FAIL reset_counters: got %h %h %h want 0", code_cnt, collision_cnt, pkt_cnt);
    end
`endif
  endtask

  task automatic test_init();
    int nr;
    int nw;
    @(negedge clk);
    rst_n = 1'b1;
    nr = 0;
    nw = 0;
    for (int k = 0; k < 20000; k++) begin
      @(posedge clk); #1;
      if (data_ready) break;
      nr++;
      if (dict_wren) nw++;
    end
    // INIT covers edges 1..16384; ready is first seen high after edge 16384.
    checks++;
    if (nr != 16383) begin
      errors++;
      $display("FAIL init_ready_low: got %0d cycles want 16383", nr);
    end
    checks++;
    if (nw != 16383) begin
      errors++;
      $display("FAIL init_wren_count: got %0d want 16383", nw);
    end
    checks++;
    if ({dict_wren, dict_addr} !== {1'b1, 14'h3FFF}) begin
      errors++;
      $display("FAIL init_last_write: got wren=%b addr=%h want 1/3fff", dict_wren, dict_addr);
    end
    @(posedge clk); #1;
    checks++;
    if (dict_wren !== 1'b0) begin
      errors++;
      $display("FAIL init_wren_stop: got %b want 0", dict_wren);
    end
    checks++;
    if (mem[14'h0041] !== 23'h400041) begin
      errors++;
      $display("FAIL init_root_41: got %h want 400041", mem[14'h0041]);
    end
    checks++;
    if ((mem[14'h0100] !== 23'h0) || (mem[14'h3FFF] !== 23'h0)) begin
      errors++;
      $display("FAIL init_clear: got %h %h want 0 0", mem[14'h0100], mem[14'h3FFF]);
    end
  endtask

  task automatic test_basic();
    int base, wbase, n;
    logic [14:0] exp_code [3];
    logic [14:0] obs;
    exp_code[0] = {1'b0, 14'h0041};
    exp_code[1] = {1'b0, 14'h0042};
    exp_code[2] = {1'b1, 14'h10C3};
    base  = codes.size();
    wbase = wr_addrs.size();
    send_byte(8'h41, 1'b0);
    send_byte(8'h42, 1'b0);
    send_byte(8'h41, 1'b0);
    send_byte(8'h42, 1'b1);
    n = 0;
    while (codes.size() < base + 3 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (codes.size() != base + 3) begin
      errors++;
      $display("FAIL basic_code_count: got %0d want 3", codes.size() - base);
    end
    for (int i = 0; i < 3; i++) begin
      obs = (codes.size() > base + i) ? {lasts[base+i], codes[base+i]} : 15'h7FFF;
      checks++;
      if (obs !== exp_code[i]) begin
        errors++;
        $display("FAIL basic_code%0d: got last/code %h want %h", i, obs, exp_code[i]);
      end
    end
    // (41,42): 0x41 ^ 0x1082 = 0x10C3.  (42,41): 0x42 ^ 0x1041 = 0x1003.
    checks++;
    if (wr_addrs.size() != wbase + 2) begin
      errors++;
      $display("FAIL basic_write_count: got %0d want 2", wr_addrs.size() - wbase);
    end else begin
      checks++;
      if ({wr_addrs[wbase], wr_dins[wbase]} !== {14'h10C3, 23'h404142}) begin
        errors++;
        $display("FAIL basic_write0: got %h/%h want 10c3/404142", wr_addrs[wbase], wr_dins[wbase]);
      end
      checks++;
      if ({wr_addrs[wbase+1], wr_dins[wbase+1]} !== {14'h1003, 23'h404241}) begin
        errors++;
        $display("FAIL basic_write1: got %h/%h want 1003/404241",
                 wr_addrs[wbase+1], wr_dins[wbase+1]);
      end
    end
    n = 0;
    while (!data_ready && n < 20000) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (!data_ready) begin
      errors++;
      $display("FAIL basic_reinit_timeout: ready=%b want 1", data_ready);
    end
  endtask

  task automatic test_single();
    int base, rbase, n;
    logic [14:0] obs;
    base  = codes.size();
    rbase = rden_cnt;
    send_byte(8'h7F, 1'b1);
    // FLUSH -> INIT takes one edge, then INIT runs 16384 edges.
    n = 0;
    while (!data_ready && n < 20000) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n != 16385) begin
      errors++;
      $display("FAIL single_reinit_len: got %0d edges want 16385", n);
    end
    checks++;
    if (codes.size() != base + 1) begin
      errors++;
      $display("FAIL single_code_count: got %0d want 1", codes.size() - base);
    end
    obs = (codes.size() > base) ? {lasts[base], codes[base]} : 15'h7FFF;
    checks++;
    if (obs !== {1'b1, 14'h007F}) begin
      errors++;
      $display("FAIL single_code: got last/code %h want %h", obs, {1'b1, 14'h007F});
    end
    checks++;
    if (rden_cnt != rbase) begin
      errors++;
      $display("FAIL single_no_read: got %0d reads want 0", rden_cnt - rbase);
    end
  endtask

  task automatic test_collision();
    int base, wbase, n, hits;
    logic [7:0]  seq      [6];
    logic [14:0] exp_code [6];
    logic [14:0] obs;
    seq[0] = 8'h41; seq[1] = 8'h42; seq[2] = 8'h00;
    seq[3] = 8'h43; seq[4] = 8'h00; seq[5] = 8'h43;
    exp_code[0] = {1'b0, 14'h0041};
    exp_code[1] = {1'b0, 14'h0042};
    exp_code[2] = {1'b0, 14'h0000};
    exp_code[3] = {1'b0, 14'h0043};
    exp_code[4] = {1'b0, 14'h0000};
    exp_code[5] = {1'b1, 14'h0043};
    base  = codes.size();
    wbase = wr_addrs.size();
    for (int i = 0; i < 6; i++) send_byte(seq[i], (i == 5));
    n = 0;
    while (codes.size() < base + 6 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (codes.size() != base + 6) begin
      errors++;
      $display("FAIL coll_code_count: got %0d want 6", codes.size() - base);
    end
    for (int i = 0; i < 6; i++) begin
      obs = (codes.size() > base + i) ? {lasts[base+i], codes[base+i]} : 15'h7FFF;
      checks++;
      if (obs !== exp_code[i]) begin
        errors++;
        $display("FAIL coll_code%0d: got last/code %h want %h", i, obs, exp_code[i]);
      end
    end
    // Learned: (41,42)@10C3, (42,00)@0142, (43,00)@0143; both (00,43) collide at 10C3.
    checks++;
    if (wr_addrs.size() != wbase + 3) begin
      errors++;
      $display("FAIL coll_write_count: got %0d want 3", wr_addrs.size() - wbase);
    end
    hits = 0;
    for (int i = wbase; i < wr_addrs.size(); i++) if (wr_addrs[i] == 14'h10C3) hits++;
    checks++;
    if (hits != 1) begin
      errors++;
      $display("FAIL coll_10c3_writes: got %0d want 1", hits);
    end
    checks++;
    if (mem[14'h0142] !== 23'h404200 || mem[14'h0143] !== 23'h404300) begin
      errors++;
      $display("FAIL coll_entries: got %h %h want 404200 404300", mem[14'h0142], mem[14'h0143]);
    end
`ifdef LZW_STATE_CNT_EN
    checks++;
    if ({code_cnt, collision_cnt, pkt_cnt} !== {32'd10, 32'd2, 32'd3}) begin
      errors++;
      $display("FAIL coll_counters: got %0d %0d %0d want 10 2 3",
               code_cnt, collision_cnt, pkt_cnt);
    end
`endif
    n = 0;
    while (!data_ready && n < 20000) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (!data_ready) begin
      errors++;
      $display("FAIL coll_reinit_timeout: ready=%b want 1", data_ready);
    end
  endtask

  // I_data_en held high across READ/WAIT/CMP; the packet is left open for the reset test.
  task automatic test_back_to_back();
    logic [7:0]  seq [3];
    int          acc [3];
    int          i, cyc, guard, base, n;
    logic        rdy;
    logic [14:0] obs;
    seq[0] = 8'h10; seq[1] = 8'h20; seq[2] = 8'h30;
    base = codes.size();
    i = 0; cyc = 0; guard = 0;
    data_en = 1'b1;
    while (i < 3 && guard < 200) begin
      data      = seq[i];
      data_last = 1'b0;
      rdy       = data_ready;
      @(posedge clk); #1;
      cyc++; guard++;
      if (rdy) begin
        acc[i] = cyc;
        i++;
      end
    end
    data_en = 1'b0;
    checks++;
    if (i != 3) begin
      errors++;
      $display("FAIL b2b_accepts: got %0d want 3", i);
    end else begin
      checks++;
      if (acc[1] - acc[0] != 1) begin
        errors++;
        $display("FAIL b2b_gap_first: got %0d want 1", acc[1] - acc[0]);
      end
      checks++;
      if (acc[2] - acc[1] != RD_LAT + 3) begin
        errors++;
        $display("FAIL b2b_gap_lookup: got %0d want %0d", acc[2] - acc[1], RD_LAT + 3);
      end
    end
    n = 0;
    while (codes.size() < base + 2 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (codes.size() != base + 2) begin
      errors++;
      $display("FAIL b2b_code_count: got %0d want 2", codes.size() - base);
    end
    obs = (codes.size() > base) ? {lasts[base], codes[base]} : 15'h7FFF;
    checks++;
    if (obs !== {1'b0, 14'h0010}) begin
      errors++;
      $display("FAIL b2b_code0: got last/code %h want %h", obs, {1'b0, 14'h0010});
    end
    obs = (codes.size() > base + 1) ? {lasts[base+1], codes[base+1]} : 15'h7FFF;
    checks++;
    if (obs !== {1'b0, 14'h0020}) begin
      errors++;
      $display("FAIL b2b_code1: got last/code %h want %h", obs, {1'b0, 14'h0020});
    end
  endtask

  task automatic test_reset_mid();
    int base;
    logic [55:0] obs;
    base = codes.size();
    send_byte(8'h41, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    obs = {data_ready, cdata_en, clast, cdata, dict_rden, dict_wren, dict_addr, dict_din};
    checks++;
    if (obs !== 56'h0) begin
      errors++;
      $display("FAIL midrst_outputs: got %h want 0", obs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    state_clr = 1'b1;
    @(posedge clk); #1;
    state_clr = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (codes.size() != base) begin
      errors++;
      $display("FAIL midrst_stray_code: got %0d codes want 0", codes.size() - base);
    end
    checks++;
    if ({data_ready, dict_wren} !== 2'b01) begin
      errors++;
      $display("FAIL midrst_in_init: got ready=%b wren=%b want 0/1", data_ready, dict_wren);
    end
`ifdef LZW_STATE_CNT_EN
    checks++;
    if ({code_cnt, collision_cnt, pkt_cnt} !== 96'h0) begin
      errors++;
      $display("FAIL midrst_counters: got %0d %0d %0d want 0", code_cnt, collision_cnt, pkt_cnt);
    end
`endif
  endtask

  initial begin
    rst_n     = 1'b0;
    state_clr = 1'b0;
    data      = 8'h00;
    data_en   = 1'b0;
    data_last = 1'b0;
    test_reset();
    test_init();
    test_basic();
    test_single();
    test_collision();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
